wireless_config_tx: RTL and testbench
=====================================

# wireless_config_tx

UART transmitter that configures the wireless sensor module. It places the module in command mode by driving `wireless_set` low, then streams a byte sequence as 8N1 serial on `wireless_rx`, and finally returns the module to transparent mode. It is the transmit counterpart of the byte receiver inside `sensor`. It sits beside `sensor` in `mod_top`, which arbitrates ownership of `wireless_rx`/`wireless_set`. A small command ROM or sequencer feeds it bytes.

## Interface

- `CLK_FREQ`, default 100_000_000: input clock frequency in Hz.
- `BAUD`, default 9600: serial bit rate. `BAUD_DIV = CLK_FREQ / BAUD`, using integer division and truncation; must be ≥ 2.
- `SETTLE_CYCLES`, default 4_000_000: cycles `wireless_set` is held low before the first byte (40 ms).
- `EXIT_CYCLES`, default 8_000_000: cycles `wireless_set` stays low after the last stop bit (80 ms).

Ports:

- `clk` in 1: system clock (`clk_100m` domain).
- `rst` in 1: **asynchronous, active-high reset.**
- `start` in 1: single-cycle request to begin a configuration session. Ignored while `busy`.
- `in_data` in 8: byte to transmit.
- `in_valid` in 1: `in_data`/`in_last` valid.
- `in_last` in 1: marks the final byte of the session.
- `in_ready` out 1: block accepts a byte this cycle.
- `busy` out 1: session in progress.
- `done` out 1: one-cycle pulse when the session completes.
- `wireless_rx` out 1: serial line into the module; idle high.
- `wireless_set` out 1: module SET pin; 0 = command mode, 1 = normal.

## Operation

- All outputs are registered except `in_ready`, which is decoded from state (`in_ready = (state == FETCH)`).
- Reset values: `wireless_rx=1`, `wireless_set=1`, `busy=0`, `done=0`, state `IDLE`, all counters 0.
- States:
  - **IDLE:** line high, set high. `start=1` → SETTLE; on that edge `wireless_set←0` and `busy←1`.
  - **SETTLE:** counts `SETTLE_CYCLES`, then → FETCH.
  - **FETCH:** `in_ready=1`, line high. On handshake (`in_valid && in_ready`), latch the byte and `in_last`, set `wireless_rx←0` (start bit), → START. Waits indefinitely for `in_valid`.
  - **START:** line 0 for `BAUD_DIV` cycles → DATA.
  - **DATA:** bits 0..7, LSB first, each `BAUD_DIV` cycles; a 3-bit index. After bit 7 → STOP.
  - **STOP:** line 1 for `BAUD_DIV` cycles. Then go to EXIT if the latched last flag is set, otherwise to FETCH.
  - **EXIT:** line 1, set 0, counts `EXIT_CYCLES`. On the final edge: `wireless_set←1`, `busy←0`, `done←1` → IDLE.
- `done` clears on the next cycle.
- The baud counter is `clog2(BAUD_DIV)` bits wide. It reloads at each bit boundary, with no cumulative drift: each bit is exactly `BAUD_DIV` cycles.
- Settle/exit counters are sized by `clog2` of their parameter. A parameter value of 0 means one cycle.
- `in_data`/`in_last` are sampled only on the handshake edge. Later changes have no effect on the byte in flight.
- `start` during `busy` is dropped and not queued. `start` coincident with the `done` edge is also dropped.
- `rst` mid-session: `wireless_rx` and `wireless_set` return to 1 immediately (asynchronously). Any partial frame is abandoned and no `done` is produced.
- `in_valid` outside FETCH is ignored; no byte is consumed.

## Timing

- `start` sampled at edge E0: `wireless_set`=0 and `busy`=1 from E0.
- FETCH is entered at E0+`SETTLE_CYCLES`.
- Handshake at edge H: the start bit begins at H, and the line is low for cycles H..H+`BAUD_DIV`−1. Data bit n occupies H+(n+1)·`BAUD_DIV`. The stop bit starts at H+9·`BAUD_DIV`.
- Back-to-back bytes with `in_valid` held: FETCH lasts 1 cycle. Start bits are therefore spaced 10·`BAUD_DIV`+1 cycles apart (stop bit effectively `BAUD_DIV`+1).
- Last byte handshake at H: EXIT begins at H+10·`BAUD_DIV`. `wireless_set`=1, `busy`=0 and `done`=1 at H+10·`BAUD_DIV`+`EXIT_CYCLES`.

## Test plan

All scenarios use `CLK_FREQ=1000`, `BAUD=100` (`BAUD_DIV=10`), `SETTLE_CYCLES=20`, `EXIT_CYCLES=30`.

- **Reset:** assert `rst` asynchronously between clocks → `wireless_rx=1`, `wireless_set=1`, `busy=0`, `done=0`, `in_ready=0` immediately.
- **Single byte:** `start` at cycle 0, byte `0xA5` with `in_last=1`.
  - `wireless_set` low from cycle 0 and `in_ready` at cycle 20.
  - Line pattern, 10 cycles per bit: 0,1,0,1,0,0,1,0,1,1.
  - `done` pulse 130 cycles after the handshake; `wireless_set` high on the same edge.
- **Three back-to-back bytes** ("AT\r" = `0x41`,`0x54`,`0x0D`, last flag on `0x0D`) → start bits spaced exactly 101 cycles apart; decoded bytes match; a single `done`.
- **Stalled source:** `in_valid` low for 50 cycles in FETCH between bytes → line stays 1, `wireless_set` stays 0, `busy` stays 1; transmission resumes on the handshake.
- **Start while busy:** pulse `start` during DATA → no restart, no extra `done`; the byte completes unchanged.
  - `in_data` changed mid-frame has no effect on the line.
- **Reset mid-frame:** `rst` during data bit 4 → line and set return to 1 at once, no `done`.
  - A subsequent `start` runs a full correct session.

Source files
------------

// File: rtl/wireless_config_tx_if.sv
// ---------------------------------------------------------------------------
// wireless_config_tx_if
//
// Purpose:
//   Bundles the byte-stream handshake, the session control/status signals and
//   the two wires that go to the wireless module (serial RX line and SET pin)
//   for the configuration transmitter.
//
// Signals:
//   start        : single-cycle request to open a configuration session
//   in_data[7:0] : byte to transmit
//   in_valid     : in_data / in_last are valid
//   in_last      : marks the final byte of the session
//   in_ready     : transmitter accepts a byte this cycle
//   busy         : session in progress
//   done         : one-cycle pulse when a session completes
//   wireless_rx  : serial line into the module, idles high
//   wireless_set : module SET pin, 0 = command mode, 1 = normal
//
// Modports:
//   master : the byte source / sequencer side
//   slave  : the transmitter itself
// ---------------------------------------------------------------------------
interface wireless_config_tx_if;

  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic       wireless_rx;
  logic       wireless_set;

  modport master (
    output start,
    output in_data,
    output in_valid,
    output in_last,
    input  in_ready,
    input  busy,
    input  done,
    input  wireless_rx,
    input  wireless_set
  );

  modport slave (
    input  start,
    input  in_data,
    input  in_valid,
    input  in_last,
    output in_ready,
    output busy,
    output done,
    output wireless_rx,
    output wireless_set
  );

endinterface

// File: rtl/wireless_config_tx.sv
// ---------------------------------------------------------------------------
// wireless_config_tx
//
// Purpose:
//   UART (8N1) transmitter that configures the wireless sensor module. A
//   session pulls the module SET pin low (command mode), waits for the module
//   to settle, streams bytes from a source on the wireless RX line, waits for
//   the module to digest the last command and finally releases SET again
//   (transparent mode), pulsing done.
//
// Parameters:
//   CLK_FREQ      : input clock frequency in Hz
//   BAUD          : serial bit rate; BAUD_DIV = CLK_FREQ / BAUD must be >= 2
//   SETTLE_CYCLES : cycles SET is held low before the first byte (0 = 1 cycle)
//   EXIT_CYCLES   : cycles SET stays low after the last stop bit (0 = 1 cycle)
//
// Ports:
//   clk    : system clock
//   rst    : asynchronous, active-high reset
//   io_bus : wireless_config_tx_if.slave
//            start, in_data, in_valid, in_last   (inputs)
//            in_ready, busy, done,
//            wireless_rx, wireless_set           (outputs)
//
// All outputs are registered except in_ready, which is decoded from state.
// ---------------------------------------------------------------------------
module wireless_config_tx #(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int BAUD          = 9600,
  parameter int SETTLE_CYCLES = 4_000_000,
  parameter int EXIT_CYCLES   = 8_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  wireless_config_tx_if.slave  io_bus
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int BAUD_W   = (BAUD_DIV > 1)      ? $clog2(BAUD_DIV)      : 1;
  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int EXIT_W   = (EXIT_CYCLES > 1)   ? $clog2(EXIT_CYCLES)   : 1;

  // Terminal counts. A zero-length settle/exit collapses to a single cycle,
  // so the terminal value is clamped at zero.
  localparam logic [BAUD_W-1:0]   BAUD_LAST   = BAUD_W'(BAUD_DIV - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST =
    SETTLE_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);
  localparam logic [EXIT_W-1:0]   EXIT_LAST   =
    EXIT_W'((EXIT_CYCLES > 0) ? (EXIT_CYCLES - 1) : 0);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    FETCH,
    START,
    DATA,
    STOP,
    EXIT
  } txState_t;

  txState_t            r_state;
  txState_t            w_stateNext;

  logic [BAUD_W-1:0]   r_baudCnt;
  logic [BAUD_W-1:0]   w_baudCntNext;
  logic [SETTLE_W-1:0] r_settleCnt;
  logic [SETTLE_W-1:0] w_settleCntNext;
  logic [EXIT_W-1:0]   r_exitCnt;
  logic [EXIT_W-1:0]   w_exitCntNext;
  logic [2:0]          r_bitIdx;
  logic [2:0]          w_bitIdxNext;
  logic [7:0]          r_shift;
  logic [7:0]          w_shiftNext;
  logic                r_last;
  logic                w_lastNext;

  logic                r_rx;
  logic                w_rxNext;
  logic                r_set;
  logic                w_setNext;
  logic                r_busy;
  logic                w_busyNext;
  logic                r_done;
  logic                w_doneNext;

  logic                w_baudTick;

  // A bit period ends when the baud counter reaches BAUD_DIV-1; the counter
  // is reloaded to zero at that point so every bit lasts exactly BAUD_DIV
  // cycles and no rounding error accumulates across a frame.
  assign w_baudTick = (r_baudCnt == BAUD_LAST);

  // in_ready is the only combinational output: the source may present a byte
  // whenever the transmitter is parked waiting for the next one.
  assign io_bus.in_ready     = (r_state == FETCH);
  assign io_bus.busy         = r_busy;
  assign io_bus.done         = r_done;
  assign io_bus.wireless_rx  = r_rx;
  assign io_bus.wireless_set = r_set;

  // State and datapath registers. Reset is asynchronous so that the line and
  // SET pin return to their idle-high levels the instant rst rises, dropping
  // any half-sent frame without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_baudCnt   <= '0;
      r_settleCnt <= '0;
      r_exitCnt   <= '0;
      r_bitIdx    <= '0;
      r_shift     <= '0;
      r_last      <= 1'b0;
      r_rx        <= 1'b1;
      r_set       <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_baudCnt   <= w_baudCntNext;
      r_settleCnt <= w_settleCntNext;
      r_exitCnt   <= w_exitCntNext;
      r_bitIdx    <= w_bitIdxNext;
      r_shift     <= w_shiftNext;
      r_last      <= w_lastNext;
      r_rx        <= w_rxNext;
      r_set       <= w_setNext;
      r_busy      <= w_busyNext;
      r_done      <= w_doneNext;
    end
  end

  // Next-state and next-output decode. Every registered output is computed
  // here so that it changes on the same edge as the state transition that
  // causes it (e.g. the start bit appears on the handshake edge, SET is
  // released on the final exit edge). done defaults low so it is a pulse.
  always_comb begin
    w_stateNext     = r_state;
    w_baudCntNext   = r_baudCnt;
    w_settleCntNext = r_settleCnt;
    w_exitCntNext   = r_exitCnt;
    w_bitIdxNext    = r_bitIdx;
    w_shiftNext     = r_shift;
    w_lastNext      = r_last;
    w_rxNext        = r_rx;
    w_setNext       = r_set;
    w_busyNext      = r_busy;
    w_doneNext      = 1'b0;

    case (r_state)
      IDLE: begin
        w_rxNext  = 1'b1;
        w_setNext = 1'b1;
        if (io_bus.start) begin
          w_stateNext     = SETTLE;
          w_setNext       = 1'b0;
          w_busyNext      = 1'b1;
          w_settleCntNext = '0;
        end
      end

      SETTLE: begin
        if (r_settleCnt == SETTLE_LAST) begin
          w_stateNext     = FETCH;
          w_settleCntNext = '0;
        end else begin
          w_settleCntNext = r_settleCnt + 1'b1;
        end
      end

      // Byte and last flag are captured only here, so the source is free to
      // change in_data/in_last once the handshake edge has passed.
      FETCH: begin
        w_rxNext = 1'b1;
        if (io_bus.in_valid) begin
          w_shiftNext   = io_bus.in_data;
          w_lastNext    = io_bus.in_last;
          w_rxNext      = 1'b0;
          w_baudCntNext = '0;
          w_stateNext   = START;
        end
      end

      // On leaving the start bit, bit 0 goes onto the line and the shift
      // register moves on, so the next data bit is always in r_shift[0].
      START: begin
        if (w_baudTick) begin
          w_baudCntNext = '0;
          w_bitIdxNext  = '0;
          w_rxNext      = r_shift[0];
          w_shiftNext   = {1'b0, r_shift[7:1]};
          w_stateNext   = DATA;
        end else begin
          w_baudCntNext = r_baudCnt + 1'b1;
        end
      end

      DATA: begin
        if (w_baudTick) begin
          w_baudCntNext = '0;
          if (r_bitIdx == 3'd7) begin
            w_rxNext    = 1'b1;
            w_stateNext = STOP;
          end else begin
            w_bitIdxNext = r_bitIdx + 1'b1;
            w_rxNext     = r_shift[0];
            w_shiftNext  = {1'b0, r_shift[7:1]};
          end
        end else begin
          w_baudCntNext = r_baudCnt + 1'b1;
        end
      end

      // The stop bit is BAUD_DIV cycles here; when another byte follows, the
      // single FETCH cycle stretches it to BAUD_DIV+1 on the wire.
      STOP: begin
        w_rxNext = 1'b1;
        if (w_baudTick) begin
          w_baudCntNext = '0;
          if (r_last) begin
            w_exitCntNext = '0;
            w_stateNext   = EXIT;
          end else begin
            w_stateNext = FETCH;
          end
        end else begin
          w_baudCntNext = r_baudCnt + 1'b1;
        end
      end

      // A start request arriving on the final exit edge is not seen, because
      // the state is still EXIT on that edge.
      EXIT: begin
        w_rxNext = 1'b1;
        if (r_exitCnt == EXIT_LAST) begin
          w_exitCntNext = '0;
          w_setNext     = 1'b1;
          w_busyNext    = 1'b0;
          w_doneNext    = 1'b1;
          w_stateNext   = IDLE;
        end else begin
          w_exitCntNext = r_exitCnt + 1'b1;
        end
      end

      default: begin
        w_stateNext = IDLE;
        w_rxNext    = 1'b1;
        w_setNext   = 1'b1;
        w_busyNext  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_wireless_config_tx.sv
// ---------------------------------------------------------------------------
// tb_wireless_config_tx
//
// Self-checking bench for wireless_config_tx. A timestamp-based model of the
// session timeline predicts every output on every cycle; a line decoder and a
// few hand-worked constants pin the model to known waveforms.
// ---------------------------------------------------------------------------
module tb_wireless_config_tx;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int BD       = 10;
  localparam int SETTLE   = 20;
  localparam int EXITC    = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wireless_config_tx_if bus ();

  wireless_config_tx #(
    .CLK_FREQ      (CLK_FREQ),
    .BAUD          (BAUD),
    .SETTLE_CYCLES (SETTLE),
    .EXIT_CYCLES   (EXITC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a session is a set of timestamps (when fetching may
  // begin, when the current frame started, when the exit wait began); the
  // outputs are derived from the distance to those timestamps.
  int         cyc     = 0;
  bit         mActive = 1'b0;
  int         fetchAt = 0;
  int         hsH     = -1;
  int         exitAt  = -1;
  logic [7:0] mByte   = '0;
  bit         mLast   = 1'b0;
  bit         mReady  = 1'b0;
  logic       expRx   = 1'b1;
  logic       expSet  = 1'b1;
  logic       expBusy = 1'b0;
  logic       expDone = 1'b0;
  int         mK;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0; mActive = 0; fetchAt = 0; hsH = -1; exitAt = -1;
      mReady = 0; expRx = 1; expSet = 1; expBusy = 0; expDone = 0;
    end else begin
      cyc++;
      expDone = 0;
      if (!mActive) begin
        if (bus.start) begin
          mActive = 1;
          fetchAt = cyc + ((SETTLE > 0) ? SETTLE : 1);
        end
      end else if (mReady && bus.in_valid) begin
        hsH   = cyc;
        mByte = bus.in_data;
        mLast = bus.in_last;
      end
      if (hsH >= 0 && cyc == hsH + 10 * BD) begin
        if (mLast) exitAt = cyc;
        else       fetchAt = cyc;
        hsH = -1;
      end
      if (exitAt >= 0 && cyc == exitAt + ((EXITC > 0) ? EXITC : 1)) begin
        expDone = 1;
        mActive = 0;
        exitAt  = -1;
      end
      if (hsH >= 0) begin
        mK = (cyc - hsH) / BD;
        if (mK == 0)      expRx = 1'b0;
        else if (mK <= 8) expRx = mByte[mK-1];
        else              expRx = 1'b1;
      end else begin
        expRx = 1'b1;
      end
      expSet  = !mActive;
      expBusy = mActive;
      mReady  = mActive && hsH < 0 && exitAt < 0 && cyc >= fetchAt;
    end
  end

  always @(negedge clk) begin
    checkOutput("wireless_rx",  bus.wireless_rx,  expRx);
    checkOutput("wireless_set", bus.wireless_set, expSet);
    checkOutput("busy",         bus.busy,         expBusy);
    checkOutput("done",         bus.done,         expDone);
    checkOutput("in_ready",     bus.in_ready,     mReady);
  end

  // Line decoder: on a falling line, sample the middle of each of the ten
  // bit cells and record the whole frame with its start cycle.
  logic [9:0] rxFrames[$];
  int         rxStarts[$];
  int         monStart = -1;
  int         monOff;
  logic [9:0] monFrame;
  int         doneCount = 0;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      monStart = -1;
    end else if (monStart < 0) begin
      if (bus.wireless_rx === 1'b0) monStart = cyc;
    end else begin
      monOff = cyc - monStart;
      if (monOff % BD == BD / 2) begin
        monFrame[monOff/BD] = bus.wireless_rx;
        if (monOff / BD == 9) begin
          rxFrames.push_back(monFrame);
          rxStarts.push_back(monStart);
          monStart = -1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) doneCount++;
  end

  int lastHs = -1000;

  task automatic startSession(output int s);
    bus.start = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Presents one byte. While garbling, in_valid/in_data/in_last/start are
  // randomised during the frame in flight; hold keeps in_valid high ahead of
  // FETCH so the handshake happens on the first FETCH cycle.
  task automatic applyStimulus(input logic [7:0] data, input bit last,
                               input int stall, input bit garble, input bit hold,
                               output int hs, output int rdy);
    int tries;
    tries = 0;
    forever begin
      if (bus.in_ready === 1'b1) break;
      if (tries > 600) begin
        checkOutput("ready_timeout", 32'd0, 32'd1);
        break;
      end
      if (garble && cyc < lastHs + 9 * BD) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_data  = 8'($urandom);
        bus.in_last  = 1'($urandom_range(0, 1));
        bus.start    = ($urandom_range(0, 7) == 0);
      end else begin
        bus.start    = 1'b0;
        bus.in_valid = hold;
        bus.in_data  = data;
        bus.in_last  = last;
      end
      @(negedge clk);
      tries++;
    end
    rdy = cyc;
    bus.start = 1'b0;
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_last  = last;
    hs = cyc + 1;
    lastHs = hs;
    @(negedge clk);
  endtask

  task automatic waitDone(output int dc);
    int tries;
    tries = 0;
    while (bus.done !== 1'b1 && tries < 2000) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 2000) checkOutput("done_timeout", 32'd0, 32'd1);
    dc = cyc;
    @(negedge clk);
  endtask

  int         s, hs, hs1, hs2, rdy, dc, d0, nb;
  logic [7:0] sent[$];
  logic [7:0] b;
  bit         garble, hold;
  int         stall;

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_rx",    bus.wireless_rx,  1);
    checkOutput("reset_set",   bus.wireless_set, 1);
    checkOutput("reset_busy",  bus.busy,         0);
    checkOutput("reset_ready", bus.in_ready,     0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte 0xA5
    $display("[TB] single byte");
    rxFrames.delete(); rxStarts.delete(); d0 = doneCount;
    startSession(s);
    checkOutput("set_low_after_start", bus.wireless_set, 0);
    applyStimulus(8'hA5, 1'b1, 0, 1'b0, 1'b0, hs, rdy);
    bus.in_valid = 1'b0;
    checkOutput("ready_delay", rdy - s, 20);
    waitDone(dc);
    checkOutput("done_delay", dc - hs, 130);
    checkOutput("frame_count_a5", rxFrames.size(), 1);
    if (rxFrames.size() == 1) begin
      checkOutput("frame_a5", rxFrames[0], 10'h34A);
      checkOutput("start_bit_a5", rxStarts[0], hs);
    end
    checkOutput("done_once_a5", doneCount - d0, 1);

    // Three back-to-back bytes "AT\r" with in_valid held
    $display("[TB] back-to-back AT\\r");
    rxFrames.delete(); rxStarts.delete(); d0 = doneCount;
    startSession(s);
    applyStimulus(8'h41, 1'b0, 0, 1'b0, 1'b1, hs, rdy);
    applyStimulus(8'h54, 1'b0, 0, 1'b0, 1'b1, hs, rdy);
    applyStimulus(8'h0D, 1'b1, 0, 1'b0, 1'b1, hs, rdy);
    bus.in_valid = 1'b0;
    waitDone(dc);
    checkOutput("frame_count_at", rxFrames.size(), 3);
    if (rxFrames.size() == 3) begin
      checkOutput("spacing_01", rxStarts[1] - rxStarts[0], 101);
      checkOutput("spacing_12", rxStarts[2] - rxStarts[1], 101);
      checkOutput("byte_A", rxFrames[0][8:1], 8'h41);
      checkOutput("byte_T", rxFrames[1][8:1], 8'h54);
      checkOutput("byte_CR", rxFrames[2][8:1], 8'h0D);
    end
    checkOutput("done_once_at", doneCount - d0, 1);

    // Stalled source: 50 idle FETCH cycles between bytes
    $display("[TB] stalled source");
    rxFrames.delete(); rxStarts.delete(); d0 = doneCount;
    startSession(s);
    applyStimulus(8'h5A, 1'b0, 0, 1'b0, 1'b0, hs1, rdy);
    bus.in_valid = 1'b0;
    applyStimulus(8'hC3, 1'b1, 50, 1'b0, 1'b0, hs2, rdy);
    bus.in_valid = 1'b0;
    checkOutput("stall_spacing", hs2 - hs1, 151);
    waitDone(dc);
    checkOutput("frame_count_stall", rxFrames.size(), 2);
    if (rxFrames.size() == 2) begin
      checkOutput("byte_stall0", rxFrames[0][8:1], 8'h5A);
      checkOutput("byte_stall1", rxFrames[1][8:1], 8'hC3);
    end
    checkOutput("done_once_stall", doneCount - d0, 1);

    // Start while busy, in_data changed mid-frame, start on the done edge
    $display("[TB] start while busy");
    rxFrames.delete(); rxStarts.delete(); d0 = doneCount;
    startSession(s);
    applyStimulus(8'h3C, 1'b1, 0, 1'b0, 1'b0, hs, rdy);
    bus.in_valid = 1'b0;
    while (cyc < hs + 35) @(negedge clk);
    bus.start   = 1'b1;
    bus.in_data = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < hs + 129) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("done_edge_busy", bus.busy, 0);
    repeat (60) @(negedge clk);
    checkOutput("no_restart_busy", bus.busy, 0);
    checkOutput("frame_count_busy", rxFrames.size(), 1);
    if (rxFrames.size() == 1) checkOutput("byte_busy", rxFrames[0][8:1], 8'h3C);
    checkOutput("done_once_busy", doneCount - d0, 1);

    // Reset during data bit 4 of 0x86 (bit 4 is 0)
    $display("[TB] reset mid-frame");
    rxFrames.delete(); rxStarts.delete(); d0 = doneCount;
    startSession(s);
    applyStimulus(8'h86, 1'b1, 0, 1'b0, 1'b0, hs, rdy);
    bus.in_valid = 1'b0;
    while (cyc < hs + 54) @(negedge clk);
    checkOutput("bit4_before_reset", bus.wireless_rx, 0);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rx",    bus.wireless_rx,  1);
    checkOutput("async_set",   bus.wireless_set, 1);
    checkOutput("async_busy",  bus.busy,         0);
    checkOutput("async_done",  bus.done,         0);
    checkOutput("async_ready", bus.in_ready,     0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    checkOutput("no_done_after_reset", doneCount - d0, 0);
    checkOutput("no_frame_after_reset", rxFrames.size(), 0);
    startSession(s);
    applyStimulus(8'h69, 1'b1, 0, 1'b0, 1'b0, hs, rdy);
    bus.in_valid = 1'b0;
    waitDone(dc);
    checkOutput("post_reset_done_delay", dc - hs, 130);
    checkOutput("frame_count_post", rxFrames.size(), 1);
    if (rxFrames.size() == 1) checkOutput("byte_post", rxFrames[0][8:1], 8'h69);
    checkOutput("done_once_post", doneCount - d0, 1);

    // Randomised sessions
    $display("[TB] random sessions");
    for (int n = 0; n < 10; n++) begin
      rxFrames.delete(); rxStarts.delete(); sent.delete(); d0 = doneCount;
      nb = $urandom_range(1, 4);
      startSession(s);
      lastHs = -1000;
      for (int i = 0; i < nb; i++) begin
        b      = 8'($urandom);
        garble = 1'($urandom_range(0, 1));
        stall  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0;
        hold   = (!garble && stall == 0);
        applyStimulus(b, (i == nb - 1), stall, garble, hold, hs, rdy);
        sent.push_back(b);
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      waitDone(dc);
      checkOutput("rand_frame_count", rxFrames.size(), nb);
      for (int i = 0; i < nb && i < rxFrames.size(); i++)
        checkOutput("rand_byte", rxFrames[i][8:1], sent[i]);
      checkOutput("rand_done_once", doneCount - d0, 1);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
